// File: rtl/gpio_pkg.sv
// gpio_pkg: GPIO register addresses and the input debouncer state encoding.
package gpio_pkg;

  localparam logic [31:0] GPIO_OUT_ADDR = 32'h1001_0024;
  localparam logic [31:0] GPIO_IN_ADDR  = 32'h1001_0028;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } db_state_e;

endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: 2-flop synchronizer, optional debounce FSM, committed input
// register and a combinational change event that is high in the cycle whose
// closing edge updates in_reg.
// Build option: GPIO_DEBOUNCE_EN selects the debounce FSM; without it in_reg
// follows the synchronizer output directly.
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int unsigned IN_WIDTH        = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IN_WIDTH-1:0] pins_i,
  output logic [IN_WIDTH-1:0] in_reg_o,
  output logic                change_o
);

  logic [IN_WIDTH-1:0] sync1_q, sync2_q;
  logic [IN_WIDTH-1:0] in_q, in_d;
  logic                change;

  // Two-stage synchronizer for the asynchronous pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pins_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
    $error("gpio_debounce: DEBOUNCE_CYCLES must be at least 2");
  end

  db_state_e           state_q, state_d;
  logic [IN_WIDTH-1:0] cand_q, cand_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  // Debouncer state, candidate and sample counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  // Debouncer next state: the IDLE sample counts as the first equal sample.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    in_d    = in_q;
    change  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2_q != in_q) begin
          state_d = COUNT;
          cand_d  = sync2_q;
          cnt_d   = CW'(1);
        end
      end
      COUNT: begin
        if (sync2_q == cand_q) begin
          if (cnt_q == CNT_LAST) begin
            in_d    = cand_q;
            change  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (sync2_q == in_q) begin
          state_d = IDLE;
        end else begin
          cand_d = sync2_q;
          cnt_d  = CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end
`else
  localparam int unsigned unused_debounce_cycles = DEBOUNCE_CYCLES;

  // Without debounce the committed value tracks the synchronizer every cycle.
  always_comb begin
    in_d   = sync2_q;
    change = (sync2_q != in_q);
  end
`endif

  // Committed input register.
  always_ff @(posedge clk) begin
    if (reset) in_q <= '0;
    else       in_q <= in_d;
  end

  assign in_reg_o = in_q;
  assign change_o = change;

endmodule

// File: rtl/gpio_port.sv
// gpio_port: memory-mapped GPIO with registered outputs, synchronized and
// debounced inputs, and a level interrupt on committed input change.
// Build option: GPIO_DEBOUNCE_EN enables the input debouncer.
module gpio_port
  import gpio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned IN_WIDTH        = 8,
  parameter int unsigned OUT_WIDTH       = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] GPIO_Address,
  input  logic [DATA_WIDTH-1:0] GPIO_WriteData,
  input  logic                  GPIO_MemWrite,
  output logic [DATA_WIDTH-1:0] GPIO_ReadData,
  input  logic [IN_WIDTH-1:0]   gpio_in,
  output logic [OUT_WIDTH-1:0]  gpio_out,
  output logic                  gpio_irq
);

  if (IN_WIDTH > DATA_WIDTH || OUT_WIDTH > DATA_WIDTH) begin : g_bad_cfg
    $error("gpio_port: pin widths must not exceed DATA_WIDTH");
  end

  logic                 sel_out, sel_in;
  logic [OUT_WIDTH-1:0] out_q, out_d;
  logic                 irq_q, irq_d;
  logic [IN_WIDTH-1:0]  in_reg;
  logic                 change;
  logic                 unused_wdata;

  assign sel_out      = (GPIO_Address == DATA_WIDTH'(GPIO_OUT_ADDR));
  assign sel_in       = (GPIO_Address == DATA_WIDTH'(GPIO_IN_ADDR));
  assign unused_wdata = ^GPIO_WriteData;

  gpio_debounce #(
    .IN_WIDTH        (IN_WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .pins_i   (gpio_in),
    .in_reg_o (in_reg),
    .change_o (change)
  );

  // Store decode: OUT loads the pin register, IN clears the interrupt; a
  // change event in the same cycle overrides the clear.
  always_comb begin
    out_d = out_q;
    irq_d = irq_q;
    if (GPIO_MemWrite && sel_out) out_d = GPIO_WriteData[OUT_WIDTH-1:0];
    if (GPIO_MemWrite && sel_in)  irq_d = 1'b0;
    if (change)                   irq_d = 1'b1;
  end

  // Output pin and interrupt-pending registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
      irq_q <= 1'b0;
    end else begin
      out_q <= out_d;
      irq_q <= irq_d;
    end
  end

  // Combinational load mux, zero-extended, no side effects.
  always_comb begin
    GPIO_ReadData = '0;
    if (sel_out)     GPIO_ReadData = DATA_WIDTH'(out_q);
    else if (sel_in) GPIO_ReadData = DATA_WIDTH'(in_reg);
  end

  assign gpio_out = out_q;
  assign gpio_irq = irq_q;

endmodule

// File: tb/tb_gpio_port.sv
// tb_gpio_port: table-driven register vectors plus hand-written input-path
// sequences; expectations for the input path follow GPIO_DEBOUNCE_EN.
module tb_gpio_port;

  localparam logic [31:0] A_OUT = 32'h1001_0024;
  localparam logic [31:0] A_IN  = 32'h1001_0028;
`ifdef GPIO_DEBOUNCE_EN
  localparam int DEB = 1;
  localparam int LAT = 2 + 4;
`else
  localparam int DEB = 0;
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata, rdata;
  logic        we;
  logic [7:0]  pins, gout;
  logic        irq;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  gpio_port #(
    .DATA_WIDTH      (32),
    .IN_WIDTH        (8),
    .OUT_WIDTH       (8),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .GPIO_Address   (addr),
    .GPIO_WriteData (wdata),
    .GPIO_MemWrite  (we),
    .GPIO_ReadData  (rdata),
    .gpio_in        (pins),
    .gpio_out       (gout),
    .gpio_irq       (irq)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [7:0]  exp_out;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then sample 1 after the rising edge.
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w,
                      input logic [7:0] p, input logic r);
    @(negedge clk);
    addr = a; wdata = d; we = w; pins = p; reset = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(A_IN, 32'h0, 1'b0, 8'h00, 1'b1);
    step(A_IN, 32'h0, 1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    logic [31:0] e_rd;
    logic        e_irq;
    reset = 1'b1; addr = A_IN; wdata = '0; we = 1'b0; pins = 8'h00;

    vecs[0] = '{A_OUT,          32'hDEADBEA5, 1'b1, 8'hA5, 32'h0000_00A5, 1'b0};
    vecs[1] = '{32'h1001_0020,  32'h1234_5678, 1'b1, 8'hA5, 32'h0,        1'b0};
    vecs[2] = '{A_OUT,          32'hFFFF_FFFF, 1'b0, 8'hA5, 32'h0000_00A5, 1'b0};
    vecs[3] = '{A_IN,           32'h0,         1'b0, 8'hA5, 32'h0,         1'b0};
    vecs[4] = '{A_OUT,          32'h0000_015A, 1'b1, 8'h5A, 32'h0000_005A, 1'b0};
    vecs[5] = '{A_OUT,          32'hFFFF_FFFF, 1'b1, 8'hFF, 32'h0000_00FF, 1'b0};
    vecs[6] = '{A_IN,           32'hFFFF_FFFF, 1'b1, 8'hFF, 32'h0,         1'b0};
    vecs[7] = '{32'h1001_0025,  32'h0,         1'b1, 8'hFF, 32'h0,         1'b0};
    vecs[8] = '{32'h0001_0024,  32'h0000_0011, 1'b1, 8'hFF, 32'h0,         1'b0};
    vecs[9] = '{A_OUT,          32'h0,         1'b1, 8'h00, 32'h0,         1'b0};

    // Reset state
    do_reset();
    check("rst irq", {31'b0, irq}, 32'h0);
    check("rst out", {24'b0, gout}, 32'h0);
    check("rst rd_in", rdata, 32'h0);
    addr = A_OUT; #1;
    check("rst rd_out", rdata, 32'h0);

    // Register access table
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].addr, vecs[i].wdata, vecs[i].we, 8'h00, 1'b0);
      check($sformatf("vec%0d out", i), {24'b0, gout}, {24'b0, vecs[i].exp_out});
      check($sformatf("vec%0d rd", i), rdata, vecs[i].exp_rd);
      check($sformatf("vec%0d irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
    end

    // Step 0x00 -> 0x3C held, then clear via store to IN
    for (int k = 1; k <= LAT + 1; k++) begin
      step(A_IN, 32'h0, 1'b0, 8'h3C, 1'b0);
      check($sformatf("step k=%0d rd", k), rdata, (k >= LAT) ? 32'h3C : 32'h0);
      check($sformatf("step k=%0d irq", k), {31'b0, irq}, (k >= LAT) ? 32'h1 : 32'h0);
    end
    step(A_IN, 32'hFFFF_0000, 1'b1, 8'h3C, 1'b0);
    check("clear irq", {31'b0, irq}, 32'h0);
    check("clear rd", rdata, 32'h3C);

    // Three-cycle pulse of 0x01
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      step(A_IN, 32'h0, 1'b0, (k <= 3) ? 8'h01 : 8'h00, 1'b0);
      e_rd  = (DEB == 0 && k >= 3 && k <= 5) ? 32'h1 : 32'h0;
      e_irq = (DEB == 0 && k >= 3);
      check($sformatf("pulse k=%0d rd", k), rdata, e_rd);
      check($sformatf("pulse k=%0d irq", k), {31'b0, irq}, {31'b0, e_irq});
    end

    // 0x01 for two cycles then 0x03 held: count restarts on the new value
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      step(A_IN, 32'h0, 1'b0, (k <= 2) ? 8'h01 : 8'h03, 1'b0);
      if (DEB != 0) begin
        e_rd  = (k >= 8) ? 32'h3 : 32'h0;
        e_irq = (k >= 8);
      end else begin
        e_rd  = (k >= 5) ? 32'h3 : ((k >= 3) ? 32'h1 : 32'h0);
        e_irq = (k >= 3);
      end
      check($sformatf("restart k=%0d rd", k), rdata, e_rd);
      check($sformatf("restart k=%0d irq", k), {31'b0, irq}, {31'b0, e_irq});
    end

    // Change event and clear on the same edge: set wins
    do_reset();
    for (int k = 1; k <= LAT; k++) begin
      step(A_IN, 32'h0, (k == LAT), 8'h3C, 1'b0);
    end
    check("setclr irq", {31'b0, irq}, 32'h1);
    check("setclr rd", rdata, 32'h3C);
    step(A_IN, 32'h0, 1'b0, 8'h3C, 1'b0);
    check("setclr hold irq", {31'b0, irq}, 32'h1);
    step(A_IN, 32'h0, 1'b1, 8'h3C, 1'b0);
    check("setclr late clear", {31'b0, irq}, 32'h0);

    // Reset mid-count, then normal debounce of the held pins
    do_reset();
    step(A_OUT, 32'h77, 1'b1, 8'h3C, 1'b0);
    check("mid out", {24'b0, gout}, 32'h77);
    for (int k = 2; k <= 4; k++) step(A_IN, 32'h0, 1'b0, 8'h3C, 1'b0);
    step(A_IN, 32'h0, 1'b0, 8'h3C, 1'b1);
    check("midrst rd", rdata, 32'h0);
    check("midrst irq", {31'b0, irq}, 32'h0);
    check("midrst out", {24'b0, gout}, 32'h0);
    for (int k = 1; k <= LAT + 1; k++) begin
      step(A_IN, 32'h0, 1'b0, 8'h3C, 1'b0);
      check($sformatf("postrst k=%0d rd", k), rdata, (k >= LAT) ? 32'h3C : 32'h0);
      check($sformatf("postrst k=%0d irq", k), {31'b0, irq}, (k >= LAT) ? 32'h1 : 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/gpio_port.md
# gpio_port

Memory-mapped GPIO peripheral on the data side of the single-cycle core. It sits directly downstream of the data-memory/GPIO address decoder and consumes its GPIO write strobe and data, plus the core address the decoder forwards. It returns the read word for the two GPIO locations. Asynchronous input pins are synchronized and debounced into a readable input register, and the block raises a level interrupt whenever the committed input value changes.

## Interface
- DATA_WIDTH, 32, bus data/address width
- IN_WIDTH, 8, number of input pins (≤ DATA_WIDTH)
- OUT_WIDTH, 8, number of output pins (≤ DATA_WIDTH)
- DEBOUNCE_CYCLES, 4, consecutive equal samples required to commit an input change (≥ 2)

- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- GPIO_Address  in  DATA_WIDTH  core address forwarded by decoder
- GPIO_WriteData  in  DATA_WIDTH  store data
- GPIO_MemWrite  in  1  store strobe, already qualified by decoder
- GPIO_ReadData  out  DATA_WIDTH  combinational load data
- gpio_in  in  IN_WIDTH  asynchronous input pins
- gpio_out  out  OUT_WIDTH  registered output pins
- gpio_irq  out  1  input-change pending, level

## Operation
- Address map: GPIO_OUT_ADDR = 0x10010024 (R/W), GPIO_IN_ADDR = 0x10010028 (R; a write clears the interrupt).
- Store to OUT with GPIO_MemWrite=1: out_reg <= GPIO_WriteData[OUT_WIDTH-1:0] at the next edge. gpio_out = out_reg.
- Store to IN with any data: irq_pending <= 0. Stores to other addresses are ignored.
- Load: OUT returns zero-extended out_reg. IN returns zero-extended in_reg. Any other address returns 0. The path is purely combinational, with no read side effects.
- Input path: gpio_in -> sync1 -> sync2 (2-flop synchronizer) -> debouncer -> in_reg.
- Debouncer FSM, states IDLE and COUNT, with candidate register cand and counter cnt of width clog2(DEBOUNCE_CYCLES):
  - IDLE: if sync2 != in_reg, go to COUNT with cand <= sync2 and cnt <= 1.
  - COUNT with sync2 == cand: if cnt == DEBOUNCE_CYCLES-1, commit in_reg <= cand, set the change event, and go to IDLE. Otherwise cnt++.
  - COUNT with sync2 != cand and sync2 == in_reg: go to IDLE (glitch rejected, no event).
  - COUNT with sync2 != cand and sync2 != in_reg: cand <= sync2, cnt <= 1 (restart).
- irq_pending is set by the change event. If set and clear occur in the same cycle, set wins. gpio_irq = irq_pending.

## Timing
- Reset values: sync1, sync2, cand, cnt, in_reg, out_reg = 0; state IDLE; irq_pending = 0; gpio_out = 0; gpio_irq = 0.
- Reset asserted mid-COUNT aborts the count with no commit. After reset, nonzero pins debounce normally, commit, and raise gpio_irq.
- Output write latency: gpio_out updates at the first edge after the store cycle.
- Input latency with debounce: a pin step stable from edge 0 commits to in_reg at edge 2+DEBOUNCE_CYCLES. gpio_irq rises at the same edge.
- Any sync2 disturbance shorter than DEBOUNCE_CYCLES samples never reaches in_reg.
- GPIO_ReadData reflects in_reg/out_reg in the same cycle they update, so a load after a store sees the new value.

## Configuration
- GPIO_DEBOUNCE_EN defined: the FSM above is compiled in.
- GPIO_DEBOUNCE_EN undefined: the FSM, cand and cnt are removed, and in_reg <= sync2 every cycle. Input latency is 3 edges. A change event fires on any edge where sync2 != in_reg. DEBOUNCE_CYCLES is ignored.

## Structure
- Package gpio_pkg: GPIO_OUT_ADDR and GPIO_IN_ADDR constants, debouncer state enum (IDLE, COUNT).
- One sub-module, gpio_debounce, contains the synchronizer, the FSM, in_reg and the change-event output. The top level holds address decode, out_reg, irq_pending and the read mux.

## Test plan
- Reset, pins = 0x00: all outputs 0; load IN -> 0; load OUT -> 0; gpio_irq = 0.
- Store 0xDEADBEA5 to 0x10010024: gpio_out = 0xA5 next edge; load OUT -> 0x000000A5; store to 0x10010020 leaves gpio_out unchanged.
- Pins 0x00 -> 0x3C held (D=4): in_reg = 0x3C and gpio_irq = 1 exactly at edge 6; store to 0x10010028 -> gpio_irq = 0 next edge.
- Pins pulse to 0x01 for 3 cycles, then back to 0x00: in_reg stays 0x00 and gpio_irq stays 0. Pins 0x01 for 2 cycles then 0x03 held: commit 0x03 only, with the count restarted.
- Change event and IN-address clear on the same edge: gpio_irq stays 1.
- Reset asserted at cnt=2: no commit; in_reg = 0 after reset. With GPIO_DEBOUNCE_EN undefined, a pin step commits at edge 3.
